// File: rtl/prog_sequencer.sv
// prog_sequencer: runs programs 0..NPROG-1 on a core back to back, one Start pulse each, then pulses Done.
// All outputs registered (1-cycle latency); Go honoured only in IDLE. Optional watchdog: PROG_SEQ_WDOG_EN.
module prog_sequencer #(
    parameter int unsigned NPROG     = 3,
    parameter int unsigned START_CYC = 2,
    parameter logic [15:0] TO_LIMIT  = 16'd4000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Go,
    input  logic        Ack,
    output logic        Start,
    output logic [1:0]  ProgSel,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [15:0] CycleCt
);
    typedef enum logic [2:0] {IDLE, LAUNCH, ARM, RUN, NEXT, FIN} state_t;

    localparam logic [1:0] LAST_PROG  = 2'(NPROG - 1);
    localparam logic [3:0] START_LAST = 4'(START_CYC - 1);

    state_t     state;
    logic [3:0] startCnt;
    logic       wdogHit;

`ifdef PROG_SEQ_WDOG_EN
    logic [15:0] wdogCt;
    logic        errQ;

    // Counter sits at zero outside ARM/RUN, so it restarts at every ARM entry.
    assign wdogHit = ((state == ARM) || (state == RUN)) && (wdogCt == TO_LIMIT - 16'd1);
    assign Err     = errQ;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wdogCt <= '0;
            errQ   <= 1'b0;
        end else begin
            if ((state == ARM) || (state == RUN))
                wdogCt <= wdogCt + 16'd1;
            else
                wdogCt <= '0;

            if ((state == IDLE) && Go)
                errQ <= 1'b0;
            else if (wdogHit)
                errQ <= 1'b1;
        end
    end
`else
    logic unusedToLimit;

    assign unusedToLimit = ^TO_LIMIT;
    assign wdogHit       = 1'b0;
    assign Err           = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            startCnt <= '0;
            Start    <= 1'b0;
            ProgSel  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            CycleCt  <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Go) begin
                        state    <= LAUNCH;
                        ProgSel  <= '0;
                        CycleCt  <= '0;
                        Start    <= 1'b1;
                        Busy     <= 1'b1;
                        startCnt <= '0;
                    end
                end
                LAUNCH: begin
                    if (startCnt == START_LAST) begin
                        Start <= 1'b0;
                        state <= ARM;
                    end else begin
                        startCnt <= startCnt + 4'd1;
                    end
                end
                ARM: begin
                    if (wdogHit) begin
                        state <= FIN;
                    end else if (!Ack) begin
                        state   <= RUN;
                        CycleCt <= '0;
                    end
                end
                RUN: begin
                    // The cycle that sees Ack is not counted; the count saturates.
                    if (wdogHit)
                        state <= FIN;
                    else if (Ack)
                        state <= NEXT;
                    else if (CycleCt != 16'hFFFF)
                        CycleCt <= CycleCt + 16'd1;
                end
                NEXT: begin
                    if (ProgSel == LAST_PROG) begin
                        state <= FIN;
                    end else begin
                        ProgSel  <= ProgSel + 2'd1;
                        startCnt <= '0;
                        Start    <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                FIN: begin
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Start <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized bench for prog_sequencer: reactive core model plus per-program expectations.
`timescale 1ns/1ps
module tb_prog_sequencer;
    localparam int          NPROG     = 3;
    localparam int          START_CYC = 2;
    localparam logic [15:0] TO_LIMIT  = 16'd100;

    logic        Clk = 1'b0;
    logic        Reset, Go, Ack;
    logic        Start, Busy, Done, Err;
    logic [1:0]  ProgSel;
    logic [15:0] CycleCt;

    prog_sequencer #(.NPROG(NPROG), .START_CYC(START_CYC), .TO_LIMIT(TO_LIMIT)) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .Ack(Ack), .Start(Start), .ProgSel(ProgSel),
        .Busy(Busy), .Done(Done), .Err(Err), .CycleCt(CycleCt)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    int runLens [4];
    int armDelays [4];
    int coreMode = 0;   // 0 halted, 1 waiting before leaving halt, 2 running, 3 never finishes
    int coreCnt = 0;
    bit hangMode = 0;
    bit prevStart = 0;
    int startLen = 0;
    int progIdx = 0;
    int doneCount = 0;
    int cyc = 0;
    int armCyc = 0;
    int doneCyc = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
        if (Start) begin
            if (!prevStart) begin
                checkVal("start_progsel", ProgSel, progIdx);
                checkVal("start_busy", Busy, 1);
                if (progIdx > 0)
                    checkVal("cyclect_frozen", CycleCt, runLens[progIdx-1]);
                startLen = 0;
            end
            startLen++;
        end else if (prevStart) begin
            checkVal("start_len", startLen, START_CYC);
            armCyc = cyc;
            if (hangMode) begin
                coreMode = 3;
            end else begin
                coreMode = 1;
                coreCnt  = armDelays[progIdx];
            end
            progIdx++;
        end
        prevStart = Start;

        if (Done) begin
            doneCount++;
            doneCyc = cyc;
            checkVal("done_busy", Busy, 0);
            if (!hangMode) begin
                checkVal("done_cyclect", CycleCt, runLens[NPROG-1]);
                checkVal("done_progsel", ProgSel, NPROG-1);
                checkVal("done_nprog", progIdx, NPROG);
                checkVal("done_err", Err, 0);
            end
        end

        case (coreMode)
            0: Ack = Start ? 1'($urandom_range(0, 1)) : 1'b1;
            1: begin
                if (coreCnt == 0) begin
                    Ack      = 1'b0;
                    coreMode = 2;
                    coreCnt  = runLens[progIdx-1] + 1;  // first low cycle is consumed leaving ARM
                end else begin
                    Ack = 1'b1;
                    coreCnt--;
                end
            end
            2: begin
                coreCnt--;
                if (coreCnt == 0) begin
                    Ack      = 1'b1;
                    coreMode = 0;
                end
            end
            default: Ack = 1'b0;
        endcase
    endtask

    task automatic resetModel();
        coreMode  = 0;
        Ack       = 1'b1;
        progIdx   = 0;
        prevStart = 0;
        hangMode  = 0;
    endtask

    // kind 0: random run lengths; kind 1: 10/20/30... ; delay < 0 means random ARM wait
    task automatic runSeq(input int kind, input int delay, input bit holdGo);
        int d0;
        int budget;
        d0 = doneCount;
        for (int p = 0; p < NPROG; p++) begin
            runLens[p]   = (kind == 1) ? 10 * (p + 1) : int'($urandom_range(1, 60));
            armDelays[p] = (delay >= 0) ? delay : int'($urandom_range(0, 5));
        end
        progIdx = 0;
        Go = 1'b1;
        tick();
        checkVal("go_busy", Busy, 1);
        checkVal("go_start", Start, 1);
        checkVal("go_cyclect", CycleCt, 0);
        checkVal("go_err", Err, 0);
        if (!holdGo) Go = 1'b0;
        budget = 3000;
        while (doneCount == d0 && budget > 0) begin
            tick();
            budget--;
        end
        Go = 1'b0;
        checkVal("seq_done", doneCount - d0, 1);
        tick();
        checkVal("done_pulse", Done, 0);
        if (holdGo) begin
            tick();
            tick();
            checkVal("no_rerun_busy", Busy, 0);
            checkVal("no_rerun_start", Start, 0);
        end
    endtask

    initial begin
        int d0;
        int budget;
        int startSeen;
        Reset = 1'b1;
        Go    = 1'b0;
        Ack   = 1'b1;
        tick();
        tick();
        checkVal("rst_start", Start, 0);
        checkVal("rst_progsel", ProgSel, 0);
        checkVal("rst_busy", Busy, 0);
        checkVal("rst_done", Done, 0);
        checkVal("rst_err", Err, 0);
        checkVal("rst_cyclect", CycleCt, 0);
        Reset = 1'b0;
        tick();

        runSeq(1, 0, 0);
        runSeq(0, 5, 0);
        runSeq(0, -1, 1);
        runSeq(0, -1, 0);
        for (int i = 0; i < 8; i++)
            runSeq(0, -1, 0);

        // Reset in the middle of program 1's run
        for (int p = 0; p < NPROG; p++) begin
            runLens[p]   = 20;
            armDelays[p] = 1;
        end
        progIdx = 0;
        d0 = doneCount;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        budget = 500;
        while (!(progIdx == 2 && coreMode == 2 && coreCnt == 15) && budget > 0) begin
            tick();
            budget--;
        end
        checkVal("rst_reached_run1", progIdx, 2);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        resetModel();
        checkVal("midrst_start", Start, 0);
        checkVal("midrst_progsel", ProgSel, 0);
        checkVal("midrst_busy", Busy, 0);
        checkVal("midrst_done", Done, 0);
        checkVal("midrst_err", Err, 0);
        checkVal("midrst_cyclect", CycleCt, 0);
        startSeen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (Start) startSeen++;
        end
        checkVal("midrst_no_done", doneCount - d0, 0);
        checkVal("midrst_no_start", startSeen, 0);

        // Core that never finishes its first program
        hangMode = 1;
        progIdx = 0;
        d0 = doneCount;
        Go = 1'b1;
        tick();
        Go = 1'b0;
`ifdef PROG_SEQ_WDOG_EN
        budget = 1000;
        while (doneCount == d0 && budget > 0) begin
            tick();
            budget--;
        end
        checkVal("wdog_done", doneCount - d0, 1);
        checkVal("wdog_err", Err, 1);
        checkVal("wdog_progsel", ProgSel, 0);
        checkVal("wdog_latency", (doneCyc - armCyc >= 95) && (doneCyc - armCyc <= 105), 1);
        for (int i = 0; i < 10; i++)
            tick();
        checkVal("wdog_err_sticky", Err, 1);
        checkVal("wdog_idle", Busy, 0);
        resetModel();
        tick();
        runSeq(0, -1, 0);
`else
        for (int i = 0; i < 70000; i++)
            tick();
        checkVal("sat_cyclect", CycleCt, 16'hFFFF);
        checkVal("sat_busy", Busy, 1);
        checkVal("sat_no_done", doneCount - d0, 0);
        checkVal("sat_err", Err, 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        resetModel();
        checkVal("sat_rst_busy", Busy, 0);
        tick();
        runSeq(0, -1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter NPROG, default 3: number of programs run per Go, 1..4.
REQ-002 Parameter START_CYC, default 2: Start pulse length in cycles, 1..15.
REQ-003 Parameter TO_LIMIT, default 16'd4000: watchdog limit in cycles per program.
REQ-004 Port Clk  input  1: clock; all state updates on posedge.
REQ-005 Port Reset  input  1: synchronous, active-high reset.
REQ-006 Port Go  input  1: request to run programs 0..NPROG-1 back to back.
REQ-007 Port Ack  input  1: done flag from the processor core (all-ones instruction fetched).
REQ-008 Port Start  output  1: start/hold request to the core's instruction fetch.
REQ-009 Port ProgSel  output  2: index of the program currently launched or running.
REQ-010 Port Busy  output  1: sequence in progress.
REQ-011 Port Done  output  1: one-cycle pulse when the sequence ends.
REQ-012 Port Err  output  1: sticky watchdog error flag.
REQ-013 Port CycleCt  output  16: cycle count of the current or most recent program.

Function
REQ-014 The FSM SHALL have states IDLE, LAUNCH, ARM, RUN, NEXT and FIN; all outputs are registered.
REQ-015 In IDLE with Go=1, the block SHALL set ProgSel=0, clear CycleCt and Err, and enter LAUNCH; Go is ignored in every other state.
REQ-016 LAUNCH SHALL drive Start=1 for exactly START_CYC consecutive cycles, then enter ARM; Start SHALL be 0 in all other states.
REQ-017 ARM SHALL wait for Ack=0 (core has left halt), then enter RUN on the next edge, with CycleCt cleared.
REQ-018 RUN SHALL increment CycleCt each cycle Ack=0, saturating at 16'hFFFF with no wrap; Ack=1 SHALL enter NEXT, and that cycle is not counted.
REQ-019 NEXT SHALL freeze CycleCt; if ProgSel==NPROG-1, enter FIN; otherwise increment ProgSel and enter LAUNCH.
REQ-020 FIN SHALL pulse Done=1 for exactly one cycle, then return to IDLE; ProgSel and CycleCt hold their values in IDLE.
REQ-021 Busy SHALL be 1 in every state except IDLE, and SHALL be 0 in the same cycle Done=1 is observed after FIN→IDLE. Busy=0 from the IDLE edge.
REQ-022 Ack SHALL be sampled only in ARM and RUN; Ack glitches in other states have no effect.
REQ-023 Go=1 arriving on the same edge as FIN→IDLE SHALL be ignored; a new Go must be presented while in IDLE.

Reset
REQ-024 Reset=1 at a posedge SHALL force IDLE, Start=0, ProgSel=0, Busy=0, Done=0, Err=0, CycleCt=0, and clear all internal counters.
REQ-025 Reset SHALL take priority over Go and over any in-progress sequence; no Done pulse is emitted for an aborted sequence.

Configuration
REQ-026 Macro PROG_SEQ_WDOG_EN: when defined, a watchdog counter clears on entry to ARM and counts every cycle in ARM and RUN.
REQ-027 With PROG_SEQ_WDOG_EN defined, when the watchdog reaches TO_LIMIT the block SHALL set Err=1, skip the remaining programs and enter FIN (Done still pulses).
REQ-028 Without PROG_SEQ_WDOG_EN, the block SHALL have no watchdog, Err is tied to 0 and TO_LIMIT is unused; ARM/RUN wait indefinitely.

Verification
REQ-029 Reset, then Go for 1 cycle with NPROG=3 and a core model that raises Ack after 10, 20 and 30 run cycles -> three Start pulses of 2 cycles each, ProgSel 0,1,2, and CycleCt 10/20/30 frozen at each NEXT; Done pulses once and Busy then falls.
REQ-030 Go held high for the whole sequence -> exactly one sequence runs; after Done, a fresh Go in IDLE starts a new sequence with CycleCt cleared.
REQ-031 Core model never raises Ack for 70000 cycles with the macro undefined -> CycleCt saturates at 16'hFFFF and stays Busy=1, Done=0, Err=0.
REQ-032 Same stimulus with PROG_SEQ_WDOG_EN and TO_LIMIT=100 -> Err=1 and Done pulses about 100 cycles after ARM entry; ProgSel remains 0 and Err stays 1 until the next Go.
REQ-033 Reset asserted for 1 cycle during RUN of program 1 -> all outputs return to reset values the next cycle, with no Done pulse and no Start.
REQ-034 Ack held 1 entering ARM, released after 5 cycles -> RUN is entered 1 cycle after release and CycleCt starts from 0.
